// File: rtl/sha256_pkg.sv
// sha256_pkg: shared word and round-tag types for the SHA-256 datapath
package sha256_pkg;
  localparam int SHA_WORD_W = 32;
  localparam int ROUND_TAG_W = 6;
  typedef logic [SHA_WORD_W-1:0] word_t;
  typedef logic [ROUND_TAG_W-1:0] round_tag_t;
endpackage

// File: rtl/sha256_csa_final_adder_if.sv
// sha256_csa_final_adder_if: operand-in / result-out valid-ready bundle for the T1 adder
interface sha256_csa_final_adder_if
  import sha256_pkg::*;
#(
  parameter int WIDTH = SHA_WORD_W,
  parameter int TAG_W = ROUND_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic [WIDTH-1:0] in_e;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [TAG_W-1:0] out_tag;
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_e, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag
  );
  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_e, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag
  );
endinterface

// File: rtl/csa_4_2_row.sv
// csa_4_2_row: WIDTH-wide chain of 4:2 compressors; carry output is pre-shifted and truncated
module csa_4_2_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);
  logic [WIDTH-1:0] s1, co, cin, cy;
  // inner cout depends only on a,b,c, so the cout->cin chain never ripples
  always_comb begin
    s1    = a ^ b ^ c;
    co    = (a & b) | (a & c) | (b & c);
    cin   = co << 1;
    sum   = s1 ^ d ^ cin;
    cy    = (s1 & d) | (s1 & cin) | (d & cin);
    carry = cy << 1;
  end
endmodule

// File: rtl/sha256_csa_final_adder.sv
// sha256_csa_final_adder: 3-stage pipelined 5-operand mod-2^WIDTH adder (4:2 + 3:2 reduce, split CPA)
module sha256_csa_final_adder
  import sha256_pkg::*;
#(
  parameter int WIDTH = SHA_WORD_W,
  parameter int SPLIT = 16,
  parameter int TAG_W = ROUND_TAG_W
) (
  input logic clk,
  input logic rst_n,
  sha256_csa_final_adder_if.slave bus
);
  localparam int HI = WIDTH - SPLIT;
  logic adv0, adv1, adv2, ld0, ld1, ld2;
  logic [WIDTH-1:0] s0, c0, s_st, c_st;
  logic [SPLIT:0] low;
  logic [HI-1:0] high;
  logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d, tag2_q, tag2_d;
  logic [SPLIT-1:0] lo_q, lo_d;
  logic cy_q, cy_d;
  logic [HI-1:0] shi_q, shi_d, chi_q, chi_d;
  csa_4_2_row #(.WIDTH(WIDTH)) u_row (
    .a(bus.in_a), .b(bus.in_b), .c(bus.in_c), .d(bus.in_d),
    .sum(s0), .carry(c0)
  );
  always_comb begin
    adv2   = !v2_q || bus.out_ready;
    adv1   = !v1_q || adv2;
    adv0   = !v0_q || adv1;
    ld0    = adv0 && bus.in_valid;
    ld1    = adv1 && v0_q;
    ld2    = adv2 && v1_q;
    s_st   = s0 ^ c0 ^ bus.in_e;
    c_st   = ((s0 & c0) | (s0 & bus.in_e) | (c0 & bus.in_e)) << 1;
    low    = {1'b0, s_q[SPLIT-1:0]} + {1'b0, c_q[SPLIT-1:0]};
    high   = shi_q + chi_q + {{(HI-1){1'b0}}, cy_q};
    v0_d   = adv0 ? bus.in_valid : v0_q;
    v1_d   = adv1 ? v0_q : v1_q;
    v2_d   = adv2 ? v1_q : v2_q;
    s_d    = ld0 ? s_st : s_q;
    c_d    = ld0 ? c_st : c_q;
    tag0_d = ld0 ? bus.in_tag : tag0_q;
    lo_d   = ld1 ? low[SPLIT-1:0] : lo_q;
    cy_d   = ld1 ? low[SPLIT] : cy_q;
    shi_d  = ld1 ? s_q[WIDTH-1:SPLIT] : shi_q;
    chi_d  = ld1 ? c_q[WIDTH-1:SPLIT] : chi_q;
    tag1_d = ld1 ? tag0_q : tag1_q;
    sum_d  = ld2 ? {high, lo_q} : sum_q;
    tag2_d = ld2 ? tag1_q : tag2_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s_q    <= '0;
      c_q    <= '0;
      tag0_q <= '0;
      lo_q   <= '0;
      cy_q   <= 1'b0;
      shi_q  <= '0;
      chi_q  <= '0;
      tag1_q <= '0;
      sum_q  <= '0;
      tag2_q <= '0;
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      s_q    <= s_d;
      c_q    <= c_d;
      tag0_q <= tag0_d;
      lo_q   <= lo_d;
      cy_q   <= cy_d;
      shi_q  <= shi_d;
      chi_q  <= chi_d;
      tag1_q <= tag1_d;
      sum_q  <= sum_d;
      tag2_q <= tag2_d;
    end
  end
  assign bus.in_ready  = adv0;
  assign bus.out_valid = v2_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_tag   = tag2_q;
endmodule

// File: tb/tb_sha256_csa_final_adder.sv
// tb_sha256_csa_final_adder: directed steps with a scoreboard queue for the T1 adder
module tb_sha256_csa_final_adder;
  import sha256_pkg::*;
  typedef struct packed {
    word_t      sum;
    round_tag_t tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sha256_csa_final_adder_if #(.WIDTH(32), .TAG_W(6)) bus ();
  sha256_csa_final_adder #(.WIDTH(32), .SPLIT(16), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, pops = 0, accepts = 0;
  int first_pop = -1, last_pop = -1, p0 = 0, a0 = 0, n = 0;
  word_t hold;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input word_t a, b, c, d, e, input round_tag_t t);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    bus.in_d = d;
    bus.in_e = e;
    bus.in_tag = t;
    bus.in_valid = 1'b1;
  endtask

  task automatic tick();
    exp_t x;
    word_t m;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      accepts++;
      m = bus.in_a + bus.in_b + bus.in_c + bus.in_d + bus.in_e;
      q.push_back({m, bus.in_tag});
    end
    if (bus.out_valid && bus.out_ready) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (q.size() == 0) chk("unexpected_out", 32'(bus.out_valid), 32'd0);
      else begin
        x = q.pop_front();
        chk("sb_sum", bus.out_sum, x.sum);
        chk("sb_tag", 32'(bus.out_tag), 32'(x.tag));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_lat(input word_t a, b, c, d, e, input round_tag_t t, input word_t want,
                          input string nm);
    int k;
    int acc;
    acc = accepts;
    drive(a, b, c, d, e, t);
    tick();
    bus.in_valid = 1'b0;
    chk({nm, "_accepted"}, 32'(accepts - acc), 32'd1);
    k = 0;
    while (!bus.out_valid && k < 8) begin
      tick();
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd2);
    chk({nm, "_sum"}, bus.out_sum, want);
    chk({nm, "_tag"}, 32'(bus.out_tag), 32'(t));
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.in_d = '0;
    bus.in_e = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", bus.out_sum, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    rst_n = 1'b1;
    tick();
    send_lat(32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 6'd5,
             32'h583ed017, "t1");
    send_lat(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 6'd9,
             32'hfffffffb, "t2");
    send_lat(32'h0000ffff, 32'h00000001, 32'h0, 32'h0, 32'h0, 6'd3, 32'h00010000, "t3");
    // 8 back-to-back sets, no backpressure
    p0 = pops;
    first_pop = -1;
    for (int i = 0; i < 8; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 6'(i));
      chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_count", 32'(pops - p0), 32'd8);
    chk("t4_consecutive", 32'(last_pop - first_pop), 32'd7);
    // stall: only three sets fit while out_ready is low
    bus.out_ready = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 6; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 6'(16 + i));
      tick();
    end
    hold = bus.out_sum;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_head_sum", hold, q[0].sum);
    tick();
    tick();
    chk("t5_accepted", 32'(accepts - a0), 32'd3);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_stable", bus.out_sum, hold);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    p0 = pops;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_drained", 32'(pops - p0), 32'd3);
    chk("t5_queue_empty", 32'(q.size()), 32'd0);
    // reset with two sets in flight
    drive(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 6'd20);
    tick();
    drive(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505, 6'd21);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_out_sum", bus.out_sum, 32'd0);
    chk("t6_rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete();
    tick();
    rst_n = 1'b1;
    p0 = pops;
    repeat (5) tick();
    chk("t6_no_stale", 32'(pops - p0), 32'd0);
    chk("t6_idle_valid", 32'(bus.out_valid), 32'd0);
    send_lat(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 6'd33, 32'd15, "t6_new");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
